// File: rtl/adat_i_frame_sched.sv
// adat_i_frame_sched: drains one ADAT frame buffer (CH = 8*ADAT_INPUTS channels)
// into a double-banked RAM once per frame_tick.
//
// Ports:
//   master_bclk        clock, all logic on the rising edge
//   reset              synchronous, active-high
//   frame_tick         one-cycle start-of-frame strobe
//   error[ADAT_INPUTS] per-stream fault flag (stream s = channels 8s..8s+7)
//   frame_done         one-cycle pulse when the frame is fully drained
//   addr / data / valid      frame-buffer read channel, data, data qualifier
//   ram_addr / ram_wdata / ram_we / ram_ack   RAM write handshake
//   bank               RAM bank being written this frame
//   busy               scheduler not idle
//   overrun / overrun_clr    sticky lost-tick flag and its clear (set wins)
//   frame_count        completed frames, wraps at 16 bits
//
// Optional build macro ADAT_I_SCHED_MUTE_EN: channels of a faulted stream are
// written as zero. Without it, error is ignored.
module adat_i_frame_sched #(
    parameter int ADAT_INPUTS = 1,
    parameter int RAM_AW      = 16,
    parameter int BASE_ADDR   = 0
) (
    input  logic                   master_bclk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [ADAT_INPUTS-1:0] error,
    output logic                   frame_done,
    output logic [7:0]             addr,
    input  logic [31:0]            data,
    input  logic                   valid,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic [31:0]            ram_wdata,
    output logic                   ram_we,
    input  logic                   ram_ack,
    output logic                   bank,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [15:0]            frame_count
);
    localparam int CH = 8 * ADAT_INPUTS;
    localparam logic [7:0] LAST = 8'(CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [7:0]             r_ch, r_addr;
    logic [RAM_AW-1:0]      r_ram_addr, w_ram_addr;
    logic [31:0]            r_wdata, w_wdata;
    logic                   r_bank, r_overrun;
    logic [15:0]            r_count;
    logic [ADAT_INPUTS-1:0] w_sel;
    logic                   w_err, w_start, w_lost, w_capture, w_step;

    assign w_start   = frame_tick && (r_state == S_IDLE || r_state == S_DONE);
    assign w_lost    = frame_tick && (r_state == S_REQ || r_state == S_WRITE);
    assign w_capture = r_state == S_REQ && valid;
    assign w_step    = r_state == S_WRITE && ram_ack && r_ch != LAST;

    // Stream owning the current channel is ch/8.
    assign w_sel = ADAT_INPUTS'(1) << r_ch[7:3];
    assign w_err = |(error & w_sel);

`ifdef ADAT_I_SCHED_MUTE_EN
    assign w_wdata = w_err ? 32'h0 : data;
`else
    logic w_unused_err;
    assign w_unused_err = w_err;
    assign w_wdata      = data;
`endif

    assign w_ram_addr = RAM_AW'(BASE_ADDR) + (r_bank ? RAM_AW'(CH) : '0) + RAM_AW'(r_ch);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = frame_tick ? S_REQ : S_IDLE;
            S_REQ:   w_next = valid ? S_WRITE : S_REQ;
            S_WRITE: w_next = !ram_ack ? S_WRITE : (r_ch == LAST ? S_DONE : S_REQ);
            default: w_next = frame_tick ? S_REQ : S_IDLE;
        endcase
    end

    always_ff @(posedge master_bclk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_addr     <= '0;
            r_ram_addr <= '0;
            r_wdata    <= '0;
            r_bank     <= 1'b0;
            r_overrun  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_ch   <= '0;
                r_addr <= '0;
            end
            // Address and data are frozen here so they stay stable until ram_ack.
            if (w_capture) begin
                r_ram_addr <= w_ram_addr;
                r_wdata    <= w_wdata;
            end
            if (w_step) begin
                r_ch   <= r_ch + 8'd1;
                r_addr <= r_ch + 8'd1;
            end
            if (r_state == S_DONE) begin
                r_count <= r_count + 16'd1;
                r_bank  <= ~r_bank;
            end
            r_overrun <= w_lost || (r_overrun && !overrun_clr);
        end
    end

    assign frame_done  = r_state == S_DONE;
    assign busy        = r_state != S_IDLE;
    assign ram_we      = r_state == S_WRITE;
    assign addr        = r_addr;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_wdata;
    assign bank        = r_bank;
    assign overrun     = r_overrun;
    assign frame_count = r_count;
endmodule
